// File: rtl/stream_utils_pkg.sv
// rtl/stream_utils_pkg.sv - shared lane-order constants and lane-index width helper for stream utilities
package stream_utils_pkg;

    localparam bit LANE_ORDER_LSB = 1'b1;
    localparam bit LANE_ORDER_MSB = 1'b0;

    // Width of a lane index; at least one bit even for degenerate lane counts.
    function automatic int lane_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs SCALE narrow beats into one wide word with keep mask and packet framing
module stream_packer
    import stream_utils_pkg::*;
#(
    parameter int DW_IN     = 8,
    parameter int SCALE     = 4,
    parameter bit LSB_FIRST = LANE_ORDER_LSB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW_IN-1:0]       s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [DW_IN*SCALE-1:0] m_data_o,
    output logic [SCALE-1:0]       m_keep_o,
    output logic                   m_last_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);

    localparam int IW     = lane_width(SCALE);
    localparam int DW_OUT = DW_IN * SCALE;
    localparam logic [IW-1:0] LAST_IDX = IW'(SCALE - 1);

    logic [IW-1:0]     idx;
    logic [IW-1:0]     lane;
    logic [DW_OUT-1:0] acc;
    logic [DW_OUT-1:0] acc_nxt;
    logic [SCALE-1:0]  acc_keep;
    logic [SCALE-1:0]  keep_nxt;
    logic              acc_last;
    logic              pending;
    logic              reset_hold;
    logic              wr;
    logic              rd;
    logic              complete;
    logic              slot_free;

    assign s_ready_o = !pending && !reset_hold;
    assign wr        = s_valid_i && s_ready_o;
    assign rd        = m_valid_o && m_ready_i;
    assign slot_free = !m_valid_o || m_ready_i;
    assign lane      = LSB_FIRST ? idx : (LAST_IDX - idx);
    assign complete  = wr && ((idx == LAST_IDX) || s_last_i);

    // Accumulator view including the beat arriving this cycle.
    for (genvar i = 0; i < SCALE; i++) begin : g_lane
        assign acc_nxt[i*DW_IN +: DW_IN] = (wr && lane == IW'(i)) ? s_data_i : acc[i*DW_IN +: DW_IN];
        assign keep_nxt[i]               = (wr && lane == IW'(i)) || acc_keep[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_hold <= 1'b1;
            idx        <= '0;
            acc        <= '0;
            acc_keep   <= '0;
            acc_last   <= 1'b0;
            pending    <= 1'b0;
            m_data_o   <= '0;
            m_keep_o   <= '0;
            m_last_o   <= 1'b0;
            m_valid_o  <= 1'b0;
        end else begin
            reset_hold <= 1'b0;
            if (pending) begin
                // Input is stalled; only a read can drain the parked word.
                if (rd) begin
                    m_data_o  <= acc;
                    m_keep_o  <= acc_keep;
                    m_last_o  <= acc_last;
                    m_valid_o <= 1'b1;
                    pending   <= 1'b0;
                    acc       <= '0;
                    acc_keep  <= '0;
                    acc_last  <= 1'b0;
                end
            end else if (complete) begin
                idx <= '0;
                if (slot_free) begin
                    m_data_o  <= acc_nxt;
                    m_keep_o  <= keep_nxt;
                    m_last_o  <= s_last_i;
                    m_valid_o <= 1'b1;
                    acc       <= '0;
                    acc_keep  <= '0;
                end else begin
                    acc      <= acc_nxt;
                    acc_keep <= keep_nxt;
                    acc_last <= s_last_i;
                    pending  <= 1'b1;
                end
            end else begin
                if (wr) begin
                    acc      <= acc_nxt;
                    acc_keep <= keep_nxt;
                    idx      <= idx + IW'(1);
                end
                if (rd) begin
                    m_valid_o <= 1'b0;
                    m_keep_o  <= '0;
                    m_last_o  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - directed self-checking bench for stream_packer in both lane orders
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;
    logic        s_ready_l, s_ready_m;
    logic [31:0] data_l, data_m;
    logic [3:0]  keep_l, keep_m;
    logic        last_l, last_m;
    logic        valid_l, valid_m;

    int total = 0;
    int bad   = 0;
    int words = 0;
    logic [31:0] exp_word;

    always #5 clk = ~clk;

    stream_packer #(.DW_IN(8), .SCALE(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready_l), .m_data_o(data_l), .m_keep_o(keep_l), .m_last_o(last_l),
        .m_valid_o(valid_l), .m_ready_i(m_ready)
    );

    stream_packer #(.DW_IN(8), .SCALE(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready_m), .m_data_o(data_m), .m_keep_o(keep_m), .m_last_o(last_m),
        .m_valid_o(valid_m), .m_ready_i(m_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        step();
        chk("rst_valid", valid_l, 1'b0);
        chk("rst_keep",  keep_l,  4'h0);
        chk("rst_last",  last_l,  1'b0);
        chk("rst_data",  data_l,  32'h0);
        chk("rst_ready", s_ready_l, 1'b0);
        rst_n = 1'b1;
        #1 chk("hold_ready_after_release", s_ready_l, 1'b0);
        step();
        chk("ready_after_hold", s_ready_l, 1'b1);

        // Full word, both lane orders
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b1);
        chk("full_valid",     valid_l, 1'b1);
        chk("full_data_lsb",  data_l,  32'h44332211);
        chk("full_keep_lsb",  keep_l,  4'hF);
        chk("full_last_lsb",  last_l,  1'b1);
        chk("full_data_msb",  data_m,  32'h11223344);
        chk("full_keep_msb",  keep_m,  4'hF);
        step();
        chk("full_consumed_valid", valid_l, 1'b0);
        chk("full_consumed_keep",  keep_l,  4'h0);
        chk("full_consumed_last",  last_l,  1'b0);

        // Partial flush, then a single-beat packet starting at lane 0
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        chk("part_valid",    valid_l, 1'b1);
        chk("part_data_lsb", data_l,  32'h0000BBAA);
        chk("part_keep_lsb", keep_l,  4'b0011);
        chk("part_last_lsb", last_l,  1'b1);
        chk("part_data_msb", data_m,  32'hAABB0000);
        chk("part_keep_msb", keep_m,  4'b1100);
        beat(8'hCC, 1'b1);
        chk("one_data_lsb", data_l, 32'h000000CC);
        chk("one_keep_lsb", keep_l, 4'b0001);
        chk("one_last_lsb", last_l, 1'b1);
        chk("one_keep_msb", keep_m, 4'b1000);
        step();

        // Back-pressure: first word held, second goes pending
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) beat(8'(i), 1'b0);
        chk("bp_valid",      valid_l, 1'b1);
        chk("bp_held_data",  data_l,  32'h04030201);
        chk("bp_ready_low",  s_ready_l, 1'b0);
        step();
        chk("bp_still_held", data_l,  32'h04030201);
        chk("bp_still_low",  s_ready_l, 1'b0);
        m_ready = 1'b1;
        step();
        chk("bp_second_data",  data_l,  32'h08070605);
        chk("bp_second_valid", valid_l, 1'b1);
        chk("bp_second_last",  last_l,  1'b0);
        chk("bp_ready_back",   s_ready_l, 1'b1);
        step();
        chk("bp_drained", valid_l, 1'b0);

        // Sustained throughput against a packing model
        words = 0;
        for (int i = 0; i < 64; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i * 3 + 1);
            exp_word[(i % 4) * 8 +: 8] = 8'(i * 3 + 1);
            chk("sus_ready", s_ready_l, 1'b1);
            step();
            chk("sus_valid", valid_l, (i % 4) == 3);
            if ((i % 4) == 3) begin
                chk("sus_data", data_l, exp_word);
                chk("sus_keep", keep_l, 4'hF);
                words++;
            end
        end
        s_valid = 1'b0;
        chk("sus_words", words, 16);
        step();

        // Asynchronous reset mid-word while a word sits on the output
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'hE0 + 8'(i), 1'b0);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        chk("pre_rst_valid", valid_l, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", valid_l, 1'b0);
        chk("async_rst_ready", s_ready_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst2_hold_ready", s_ready_l, 1'b0);
        step();
        chk("rst2_ready", s_ready_l, 1'b1);
        chk("rst2_no_output", valid_l, 1'b0);
        m_ready = 1'b1;
        for (int i = 5; i <= 8; i++) beat(8'(i), 1'b0);
        chk("rst2_data",  data_l,  32'h08070605);
        chk("rst2_keep",  keep_l,  4'hF);
        chk("rst2_valid", valid_l, 1'b1);
        step();
        chk("rst2_drained", valid_l, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Parametrised width upsizer for the stream_utils library: packs SCALE narrow beats of DW_IN bits into one wide beat of DW_IN*SCALE bits.
- Beyond plain upsizing, it adds packet framing (s_last_i flushes a partial word), a per-lane keep mask, and a selectable lane order.
- Has a registered output slot plus a one-word pending buffer, so it sustains one input beat per cycle while the sink accepts.
- Sits between narrow producers (ADC/peripheral streams) and wide consumers (DMA, memory writers).

Parameters:
- DW_IN, 8, input data width in bits; must be 1 or more.
- SCALE, 4, input beats per output word; must be 2 or more; lane index width is $clog2(SCALE).
- LSB_FIRST, 1: 1 means the first beat lands in bits [DW_IN-1:0]; 0 means the first beat lands in the top lane.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  DW_IN  input beat data.
- s_valid_i  in  1  input beat valid.
- s_last_i  in  1  final beat of a packet; completes the current word.
- s_ready_o  out  1  block can accept a beat.
- m_data_o  out  DW_IN*SCALE  packed word.
- m_keep_o  out  SCALE  bit i set means lane i holds valid data.
- m_last_o  out  1  word ends a packet.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  sink accepts the word.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values while rst_n=0: m_valid_o=0, m_keep_o=0, m_last_o=0, m_data_o=0, s_ready_o=0.
  - Internal reset: lane index idx=0, accumulator=0, accumulator keep=0, pending=0.
  - s_ready_o stays 0 for the first clk cycle after rst_n deasserts (registered reset-hold flag), then rises.
- Transfer rules: wr = s_valid_i & s_ready_o; rd = m_valid_o & m_ready_i. m_data/keep/last hold stable while m_valid_o=1 and m_ready_i=0.
- Lane placement: physical lane p = idx when LSB_FIRST=1, otherwise SCALE-1-idx.
- On wr:
  - s_data_i is written to accumulator lane p, and keep[p] is set.
  - The word completes when idx==SCALE-1 or s_last_i=1.
  - If not complete: idx <= idx+1.
  - If complete: idx <= 0, and the accumulator is cleared after hand-off.
- Hand-off of a completed word (including the beat arriving this cycle):
  - Output slot free (m_valid_o=0 or rd): the word goes to the output registers next cycle with m_valid_o=1 and m_last_o=s_last_i. Latency is 1 cycle from the completing beat to m_valid_o.
  - Output slot occupied and not read: the word stays in the accumulator and pending <= 1.
- Pending:
  - While pending=1, s_ready_o=0.
  - On rd with pending=1, the pending word moves to the output registers, pending <= 0, and the accumulator clears.
  - s_ready_o returns to 1 the cycle after that rd.
- s_ready_o = !pending & !reset_hold. It never depends combinationally on s_valid_i, s_data_i or s_last_i.
- Partial word (s_last_i before lane SCALE-1): unfilled lanes output data 0 with keep bit 0.
- Last beat at lane SCALE-1: keep is all ones and m_last_o=1.
- Throughput: one input beat per cycle with m_ready_i held high, giving one output word every SCALE cycles with no bubbles.
- An output word with m_valid_o=0 drives m_keep_o=0 and m_last_o=0 once consumed, i.e. they are cleared on rd when no new word loads.
- Reset mid-packet: the partial word is discarded, no output is produced for it, and the next beat after reset starts at idx=0.
- s_valid_i=1 with s_last_i=1 on the very first beat gives a 1-lane word: keep=one-hot for lane p, m_last_o=1.

Decomposition:
- Shared package stream_utils_pkg holds the lane-index width function (clog2 helper) and a LANE_ORDER_LSB/LANE_ORDER_MSB constant pair used by stream_packer and the future stream_unpacker.
- No sub-module. The output register plus pending logic is small enough to stay inline. The accumulator lane-write is a generate loop over SCALE.

Test Plan:
- Full words: DW_IN=8, SCALE=4, LSB_FIRST=1. Beats 0x11,0x22,0x33,0x44 back-to-back with last on 0x44 and m_ready_i=1 -> one cycle later m_data_o=0x44332211, m_keep_o=4'b1111, m_last_o=1, m_valid_o=1 for 1 cycle.
- Lane order: same beats with LSB_FIRST=0 -> m_data_o=0x11223344, keep=4'b1111.
- Partial flush: beats 0xAA,0xBB with s_last_i on 0xBB -> m_data_o=0x0000BBAA, m_keep_o=4'b0011, m_last_o=1; the next packet's first beat lands in lane 0.
- Back-pressure: m_ready_i=0, stream 8 beats (0x01..0x08) -> word 0x04030201 held on the output, second word goes pending, s_ready_o=0 after beat 8.
  - Raise m_ready_i -> 0x04030201 then 0x08070605 on consecutive cycles, and s_ready_o returns to 1 the cycle after the first rd.
- Sustained throughput: m_ready_i=1, 64 continuous beats -> 16 words, s_ready_o never drops, output matches a reference model.
- Reset: rst_n low mid-word after 2 beats -> m_valid_o=0 immediately (asynchronous), s_ready_o=0 for one cycle after release; the next 4 beats 0x5..0x8 give exactly 0x08070605 with keep=4'b1111.
